// File: rtl/fq_pkg.sv
// fq_pkg: shared definitions for the fetch queue.
//   FQ_MAX_LANES   - upper bound on push/pop lanes (WIDTH must not exceed it)
//   FQ_DEF_DEPTH   - default queue depth
//   FQ_DEF_CNT_W   - occupancy-count width for the default depth
//   FQ_DEF_PTR_W   - pointer width for the default depth
//   lane_vec_t     - lane bit-vector sized for the widest configuration
//   lead_ones()    - length of the run of ones starting at bit 0
package fq_pkg;

    localparam int FQ_MAX_LANES = 8;
    localparam int FQ_DEF_DEPTH = 8;
    localparam int FQ_DEF_CNT_W = $clog2(FQ_DEF_DEPTH + 1);
    localparam int FQ_DEF_PTR_W = $clog2(FQ_DEF_DEPTH);

    typedef logic [FQ_MAX_LANES-1:0] lane_vec_t;

    // Counts contiguous ones from bit 0; the first zero ends the run, so
    // 8'b0000_1011 yields 2. Callers zero-extend narrower lane vectors.
    function automatic logic [3:0] lead_ones(input lane_vec_t vec);
        logic [3:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < FQ_MAX_LANES; i++) begin
            run = run & vec[i];
            n   = n + {3'b000, run};
        end
        return n;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// fq_storage: DEPTH x (PC_WIDTH+INSTR_WIDTH) register array for the fetch queue.
//   clk          in  clock
//   wr_en_i      in  per-lane write enable
//   wr_base_i    in  write pointer; lane k writes entry wr_base_i+k (mod DEPTH)
//   wr_instr_i   in  packed lane instructions
//   wr_pc_i      in  packed lane PCs
//   rd_base_i    in  read pointer; lane k reads entry rd_base_i+k (mod DEPTH)
//   rd_instr_o   out packed lane instructions (combinational read)
//   rd_pc_o      out packed lane PCs (combinational read)
module fq_storage #(
    parameter  int INSTR_WIDTH = 32,
    parameter  int PC_WIDTH    = 32,
    parameter  int WIDTH       = 2,
    parameter  int DEPTH       = 8,
    localparam int PTR_W       = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic [WIDTH-1:0]             wr_en_i,
    input  logic [PTR_W-1:0]             wr_base_i,
    input  logic [WIDTH*INSTR_WIDTH-1:0] wr_instr_i,
    input  logic [WIDTH*PC_WIDTH-1:0]    wr_pc_i,
    input  logic [PTR_W-1:0]             rd_base_i,
    output logic [WIDTH*INSTR_WIDTH-1:0] rd_instr_o,
    output logic [WIDTH*PC_WIDTH-1:0]    rd_pc_o
);

    localparam int ENT_W = INSTR_WIDTH + PC_WIDTH;

    // Entry layout: {pc, instr}. No reset: contents past count are never shown.
    logic [DEPTH-1:0][ENT_W-1:0] mem_q;
    logic [WIDTH-1:0][PTR_W-1:0] wr_idx;
    logic [WIDTH-1:0][PTR_W-1:0] rd_idx;

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        // Pointer-width adds wrap modulo DEPTH for free (DEPTH is a power of two).
        assign wr_idx[k] = wr_base_i + PTR_W'(k);
        assign rd_idx[k] = rd_base_i + PTR_W'(k);
        assign rd_instr_o[k*INSTR_WIDTH +: INSTR_WIDTH] = mem_q[rd_idx[k]][INSTR_WIDTH-1:0];
        assign rd_pc_o[k*PC_WIDTH +: PC_WIDTH]          = mem_q[rd_idx[k]][ENT_W-1:INSTR_WIDTH];
    end

    // WIDTH <= DEPTH/2, so lanes of one push never target the same entry.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (wr_en_i[k]) begin
                mem_q[wr_idx[k]] <= {wr_pc_i[k*PC_WIDTH +: PC_WIDTH],
                                     wr_instr_i[k*INSTR_WIDTH +: INSTR_WIDTH]};
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: N-wide circular instruction queue between fetch and decode.
//   clk          in  clock
//   rst          in  synchronous active-high reset
//   flush_i      in  discard all entries (highest priority after reset)
//   in_valid_i   in  per-lane push valid, lane 0 oldest; leading run is taken
//   in_instr_i   in  packed push instructions
//   in_pc_i      in  packed push PCs
//   in_ready_o   out room for a full WIDTH-lane push (from registered count)
//   out_valid_o  out lane k holds the k-th oldest entry
//   out_instr_o  out oldest-first instructions
//   out_pc_o     out oldest-first PCs
//   out_ack_i    in  per-lane pop; leading run masked by out_valid_o is taken
//   count_o      out current occupancy
module fetch_queue
    import fq_pkg::*;
#(
    parameter  int INSTR_WIDTH = 32,
    parameter  int PC_WIDTH    = 32,
    parameter  int WIDTH       = 2,
    parameter  int DEPTH       = 8,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             in_valid_i,
    input  logic [WIDTH*INSTR_WIDTH-1:0] in_instr_i,
    input  logic [WIDTH*PC_WIDTH-1:0]    in_pc_i,
    output logic                         in_ready_o,
    output logic [WIDTH-1:0]             out_valid_o,
    output logic [WIDTH*INSTR_WIDTH-1:0] out_instr_o,
    output logic [WIDTH*PC_WIDTH-1:0]    out_pc_o,
    input  logic [WIDTH-1:0]             out_ack_i,
    output logic [CNT_W-1:0]             count_o
);

    localparam int               PTR_W     = $clog2(DEPTH);
    // Ready when DEPTH - count >= WIDTH, i.e. count <= DEPTH - WIDTH.
    localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(DEPTH - WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    logic             in_ready;
    lane_vec_t        push_vec, pop_vec;
    logic [CNT_W-1:0] push_n, pop_n;
    logic [WIDTH-1:0] wr_en;

    assign in_ready   = (count_q <= RDY_LIMIT);
    assign in_ready_o = in_ready;
    assign count_o    = count_q;

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        assign out_valid_o[k] = (count_q > CNT_W'(k));
        // Lanes below push_n are exactly the accepted leading run.
        assign wr_en[k]       = !flush_i && (push_n > CNT_W'(k));
    end

    // A push while not ready is dropped whole; acks beyond the valid
    // entries are masked so an empty queue never underflows.
    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        push_vec[WIDTH-1:0] = in_ready ? in_valid_i : '0;
        pop_vec[WIDTH-1:0]  = out_ack_i & out_valid_o;
        push_n = CNT_W'(lead_ones(push_vec));
        pop_n  = CNT_W'(lead_ones(pop_vec));
    end

    always_comb begin
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + push_n - pop_n;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fq_storage #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_WIDTH    (PC_WIDTH),
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH)
    ) u_storage (
        .clk        (clk),
        .wr_en_i    (wr_en),
        .wr_base_i  (tail_q),
        .wr_instr_i (in_instr_i),
        .wr_pc_i    (in_pc_i),
        .rd_base_i  (head_q),
        .rd_instr_o (out_instr_o),
        .rd_pc_o    (out_pc_o)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_MAX);

    // A refused push must be held until taken; a flush redirects fetch and
    // releases that obligation.
    a_push_hold: assert property (@(posedge clk) disable iff (rst)
        ((|in_valid_i) && !in_ready) |=> ($past(flush_i) || (in_valid_i == $past(in_valid_i))));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [1:0]  in_valid_i;
    logic [63:0] in_instr_i;
    logic [63:0] in_pc_i;
    logic        in_ready_o;
    logic [1:0]  out_valid_o;
    logic [63:0] out_instr_o;
    logic [63:0] out_pc_o;
    logic [1:0]  out_ack_i;
    logic [3:0]  count_o;

    int checks;
    int failures;

    fetch_queue #(
        .INSTR_WIDTH (32),
        .PC_WIDTH    (32),
        .WIDTH       (2),
        .DEPTH       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_instr_i  (in_instr_i),
        .in_pc_i     (in_pc_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_instr_o (out_instr_o),
        .out_pc_o    (out_pc_o),
        .out_ack_i   (out_ack_i),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid_i = '0; in_instr_i = '0; in_pc_i = '0; out_ack_i = '0; flush_i = 1'b0;
    endtask

    // Apply one cycle of stimulus; inputs stay applied until changed.
    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic [1:0] ack, input logic fl);
        in_valid_i = v; in_instr_i = {i1, i0}; in_pc_i = {p1, p0};
        out_ack_i = ack; flush_i = fl;
        cyc();
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", out_valid_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_push_basic();
        do_reset();
        drive(2'b11, 32'h00000013, 32'h100, 32'h00100093, 32'h104, 2'b00, 1'b0);
        clr();
        checks++; if (out_valid_o !== 2'b11) begin failures++; $display("FAIL push_valid got=%b exp=11", out_valid_o); end
        checks++; if (out_pc_o[31:0] !== 32'h100) begin failures++; $display("FAIL push_pc0 got=%h exp=100", out_pc_o[31:0]); end
        checks++; if (out_pc_o[63:32] !== 32'h104) begin failures++; $display("FAIL push_pc1 got=%h exp=104", out_pc_o[63:32]); end
        checks++; if (out_instr_o[63:32] !== 32'h00100093) begin failures++; $display("FAIL push_instr1 got=%h exp=00100093", out_instr_o[63:32]); end
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL push_count got=%0d exp=2", count_o); end
    endtask

    task automatic test_fill();
        do_reset();
        drive(2'b11, 32'h1000, 32'h200, 32'h1001, 32'h204, 2'b00, 1'b0);
        drive(2'b11, 32'h1002, 32'h208, 32'h1003, 32'h20C, 2'b00, 1'b0);
        drive(2'b11, 32'h1004, 32'h210, 32'h1005, 32'h214, 2'b00, 1'b0);
        drive(2'b11, 32'h1006, 32'h218, 32'h1007, 32'h21C, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count_o); end
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", in_ready_o); end
        checks++; if (out_pc_o[31:0] !== 32'h200) begin failures++; $display("FAIL fill_pc0 got=%h exp=200", out_pc_o[31:0]); end
        // Fifth push refused while full; held until it gets in.
        drive(2'b11, 32'hDEAD0000, 32'h300, 32'hDEAD0001, 32'h304, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL full_drop_count got=%0d exp=8", count_o); end
        checks++; if (out_instr_o[63:32] !== 32'h1001) begin failures++; $display("FAIL full_drop_instr1 got=%h exp=1001", out_instr_o[63:32]); end
        // Pop 2 while still full: ready is registered, so the push stays refused.
        drive(2'b11, 32'hDEAD0000, 32'h300, 32'hDEAD0001, 32'h304, 2'b11, 1'b0);
        checks++; if (count_o !== 4'd6) begin failures++; $display("FAIL full_pop_count got=%0d exp=6", count_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b exp=1", in_ready_o); end
        checks++; if (out_pc_o[31:0] !== 32'h208) begin failures++; $display("FAIL full_pop_pc0 got=%h exp=208", out_pc_o[31:0]); end
        drive(2'b11, 32'hDEAD0000, 32'h300, 32'hDEAD0001, 32'h304, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd8) begin failures++; $display("FAIL held_push_count got=%0d exp=8", count_o); end
        clr();
        drive(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
        drive(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
        drive(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
        clr();
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL drain_count got=%0d exp=2", count_o); end
        checks++; if (out_pc_o[31:0] !== 32'h300) begin failures++; $display("FAIL drain_pc0 got=%h exp=300", out_pc_o[31:0]); end
        checks++; if (out_instr_o[31:0] !== 32'hDEAD0000) begin failures++; $display("FAIL drain_instr0 got=%h exp=dead0000", out_instr_o[31:0]); end
        checks++; if (out_pc_o[63:32] !== 32'h304) begin failures++; $display("FAIL drain_pc1 got=%h exp=304", out_pc_o[63:32]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(2'b11, 32'h2000, 32'h400, 32'h2001, 32'h404, 2'b00, 1'b0);
        drive(2'b11, 32'h2002, 32'h408, 32'h2003, 32'h40C, 2'b00, 1'b0);
        drive(2'b11, 32'h2004, 32'h410, 32'h2005, 32'h414, 2'b00, 1'b0);
        // count=6: push 2 and pop 2 together; tail wraps 6 -> 0.
        drive(2'b11, 32'h2006, 32'h418, 32'h2007, 32'h41C, 2'b11, 1'b0);
        clr();
        checks++; if (count_o !== 4'd6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", count_o); end
        checks++; if (out_pc_o[31:0] !== 32'h408) begin failures++; $display("FAIL b2b_pc0 got=%h exp=408", out_pc_o[31:0]); end
        checks++; if (out_instr_o[31:0] !== 32'h2002) begin failures++; $display("FAIL b2b_instr0 got=%h exp=2002", out_instr_o[31:0]); end
        drive(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
        drive(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
        clr();
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", count_o); end
        checks++; if (out_pc_o[31:0] !== 32'h418) begin failures++; $display("FAIL wrap_pc0 got=%h exp=418", out_pc_o[31:0]); end
        checks++; if (out_instr_o[63:32] !== 32'h2007) begin failures++; $display("FAIL wrap_instr1 got=%h exp=2007", out_instr_o[63:32]); end
    endtask

    task automatic test_partial_lanes();
        do_reset();
        // Ack on empty is masked; push still lands.
        drive(2'b11, 32'h3000, 32'h500, 32'h3001, 32'h504, 2'b11, 1'b0);
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL empty_ack_count got=%0d exp=2", count_o); end
        checks++; if (out_pc_o[31:0] !== 32'h500) begin failures++; $display("FAIL empty_ack_pc0 got=%h exp=500", out_pc_o[31:0]); end
        // Lane 1 only: leading run is empty, nothing enqueued.
        drive(2'b10, 32'h3AAA, 32'h5AA, 32'h3BBB, 32'h5BB, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL lane1_only_count got=%0d exp=2", count_o); end
        drive(2'b01, 32'h3002, 32'h508, 32'h3CCC, 32'h5CC, 2'b00, 1'b0);
        clr();
        checks++; if (count_o !== 4'd3) begin failures++; $display("FAIL one_lane_count got=%0d exp=3", count_o); end
        drive(2'b00, 0, 0, 0, 0, 2'b10, 1'b0);
        checks++; if (count_o !== 4'd3) begin failures++; $display("FAIL ack10_count got=%0d exp=3", count_o); end
        checks++; if (out_pc_o[31:0] !== 32'h500) begin failures++; $display("FAIL ack10_pc0 got=%h exp=500", out_pc_o[31:0]); end
        drive(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL ack01_count got=%0d exp=2", count_o); end
        checks++; if (out_pc_o[63:32] !== 32'h508) begin failures++; $display("FAIL ack01_pc1 got=%h exp=508", out_pc_o[63:32]); end
        drive(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
        clr();
        checks++; if (out_valid_o !== 2'b01) begin failures++; $display("FAIL one_left_valid got=%b exp=01", out_valid_o); end
        checks++; if (out_pc_o[31:0] !== 32'h508) begin failures++; $display("FAIL one_left_pc0 got=%h exp=508", out_pc_o[31:0]); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(2'b11, 32'h4000, 32'h600, 32'h4001, 32'h604, 2'b00, 1'b0);
        drive(2'b11, 32'h4002, 32'h608, 32'h4003, 32'h60C, 2'b00, 1'b0);
        drive(2'b01, 32'h4004, 32'h610, 32'h0, 32'h0, 2'b00, 1'b0);
        checks++; if (count_o !== 4'd5) begin failures++; $display("FAIL preflush_count got=%0d exp=5", count_o); end
        drive(2'b11, 32'h4F00, 32'h6F0, 32'h4F01, 32'h6F4, 2'b01, 1'b1);
        clr();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count_o); end
        checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL flush_valid got=%b exp=00", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready_o); end
        drive(2'b11, 32'h4010, 32'h700, 32'h4011, 32'h704, 2'b00, 1'b0);
        clr();
        checks++; if (out_pc_o[31:0] !== 32'h700) begin failures++; $display("FAIL postflush_pc0 got=%h exp=700", out_pc_o[31:0]); end
        checks++; if (out_instr_o[31:0] !== 32'h4010) begin failures++; $display("FAIL postflush_instr0 got=%h exp=4010", out_instr_o[31:0]); end
        checks++; if (count_o !== 4'd2) begin failures++; $display("FAIL postflush_count got=%0d exp=2", count_o); end
        // Reset mid-operation beats a same-cycle push.
        rst = 1'b1;
        drive(2'b11, 32'h4020, 32'h710, 32'h4021, 32'h714, 2'b00, 1'b0);
        rst = 1'b0;
        clr();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count_o); end
        checks++; if (out_valid_o !== 2'b00) begin failures++; $display("FAIL midrst_valid got=%b exp=00", out_valid_o); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        clr();
        test_reset();
        test_push_basic();
        test_fill();
        test_back_to_back();
        test_partial_lanes();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
